warrants_code_lookup: RTL and testbench



---
 rtl/warrants_lookup_pkg.sv | 22 ++
 rtl/warrants_lookup_stats.sv | 24 ++
 rtl/warrants_code_lookup.sv | 137 +++++++++++++
 tb/tb_warrants_code_lookup.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/warrants_lookup_pkg.sv
// Shared types and helpers for the warrant code lookup block: widths, the
// empty-entry marker, the lookup FSM states and the table hash.
package warrants_lookup_pkg;

  localparam int ADDR_W = 10;
  localparam int CODE_W = 48;

  localparam logic [CODE_W-1:0] EMPTY_CODE = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HWR   = 2'd1,
    PROBE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Fold the 48-bit code into a 10-bit home slot.
  function automatic logic [ADDR_W-1:0] code_hash(input logic [CODE_W-1:0] code);
    return code[9:0] ^ code[19:10] ^ code[29:20] ^ code[39:30] ^ {2'b00, code[47:40]};
  endfunction

endpackage

// File: rtl/warrants_lookup_stats.sv
// Saturating hit/miss counters, stepped once per accepted lookup result.
module warrants_lookup_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        rsp_fire,
  input  logic        rsp_hit,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rsp_fire) begin
      if (rsp_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/warrants_code_lookup.sv
// Warrant code lookup: hashes a 6-char code, probes the code RAM linearly and
// shares the RAM port with host table writes. WARRANT_LOOKUP_STATS_EN adds counters.
module warrants_code_lookup
  import warrants_lookup_pkg::*;
#(
  parameter int MAX_PROBE = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Lookup request and result channels: a transfer happens on a clock edge
  // where valid && ready; the sender keeps valid and payload stable until then.
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_index,
  output logic [4:0]        rsp_probes,
  input  logic              host_wr_req,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [CODE_W-1:0] host_wr_data,
  output logic              host_wr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CODE_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [CODE_W-1:0] ram_dout,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output state_e            dbg_state
);

  localparam logic [3:0]        LAST_PROBE = 4'(MAX_PROBE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  state_e            state;
  logic [CODE_W-1:0] code_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        probe_cnt;

  logic probe_hit;
  logic probe_done;

  // An all-zero code can never hit: it would match every empty slot.
  assign probe_hit  = (code_q != EMPTY_CODE) && (ram_dout == code_q);
  assign probe_done = probe_hit || (code_q == EMPTY_CODE) ||
                      (ram_dout == EMPTY_CODE) || (probe_cnt == LAST_PROBE);

  assign dbg_state = state;
  assign req_ready = !reset && (state == IDLE) && !host_wr_req;
  assign ram_we    = !reset && (state == IDLE) && host_wr_req;

  // The RAM address is steered combinationally so the read issued in the
  // accepting cycle returns data in the first PROBE cycle.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (host_wr_req) begin
            ram_addr = host_wr_addr;
            ram_din  = host_wr_data;
          end else if (req_valid) begin
            ram_addr = code_hash(req_code);
          end
        end
        PROBE:   ram_addr = cur_addr + ADDR_ONE;
        default: ram_addr = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      code_q      <= '0;
      cur_addr    <= '0;
      probe_cnt   <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_index   <= '0;
      rsp_probes  <= '0;
      host_wr_ack <= 1'b0;
    end else begin
      host_wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (host_wr_req) begin
            host_wr_ack <= 1'b1;
            state       <= HWR;
          end else if (req_valid) begin
            code_q    <= req_code;
            cur_addr  <= code_hash(req_code);
            probe_cnt <= '0;
            state     <= PROBE;
          end
        end
        HWR: state <= IDLE;
        PROBE: begin
          if (probe_done) begin
            rsp_valid  <= 1'b1;
            rsp_hit    <= probe_hit;
            rsp_index  <= cur_addr;
            rsp_probes <= 5'(probe_cnt) + 5'd1;
            state      <= RESP;
          end else begin
            probe_cnt <= probe_cnt + 4'd1;
            cur_addr  <= cur_addr + ADDR_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WARRANT_LOOKUP_STATS_EN
  warrants_lookup_stats u_stats (
    .clk      (clk),
    .reset    (reset),
    .rsp_fire (rsp_valid && rsp_ready),
    .rsp_hit  (rsp_hit),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_warrants_code_lookup.sv
// Bench for warrants_code_lookup: behavioural RAM sibling, table of directed
// vectors, hand sequences for multi-cycle corners and a randomized phase.
module tb_warrants_code_lookup;
  import warrants_lookup_pkg::*;

  localparam int MAX_PROBE = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [CODE_W-1:0] req_code;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [ADDR_W-1:0] rsp_index;
  logic [4:0]        rsp_probes;
  logic              host_wr_req;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [CODE_W-1:0] host_wr_data;
  logic              host_wr_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [CODE_W-1:0] ram_din;
  logic              ram_we;
  logic [CODE_W-1:0] ram_dout;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
  state_e            dbg_state;

  warrants_code_lookup #(.MAX_PROBE(MAX_PROBE)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_code     (req_code),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_hit      (rsp_hit),
    .rsp_index    (rsp_index),
    .rsp_probes   (rsp_probes),
    .host_wr_req  (host_wr_req),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ack  (host_wr_ack),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_dout     (ram_dout),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CODE_W-1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [CODE_W-1:0] ref_tab [1024];
  logic [15:0]       exp_q[$];
  int unsigned       exp_hit_cnt = 0;
  int unsigned       exp_miss_cnt = 0;
  int                checks = 0;
  int                errors = 0;

  function automatic int ref_hash(input logic [CODE_W-1:0] c);
    longint unsigned v;
    int h;
    v = 64'(c);
    h = 0;
    for (int f = 0; f < 5; f++) h = h ^ int'((v >> (10 * f)) % 1024);
    return h;
  endfunction

  function automatic logic [15:0] ref_lookup(input logic [CODE_W-1:0] c);
    logic       hit;
    int         idx;
    int         probes;
    hit = 1'b0; idx = 0; probes = 0;
    for (int k = 0; k < MAX_PROBE; k++) begin
      idx    = (ref_hash(c) + k) % 1024;
      probes = k + 1;
      if (c == 0) break;
      if (ref_tab[idx] == c) begin hit = 1'b1; break; end
      if (ref_tab[idx] == 0) break;
    end
    return {hit, 10'(idx), 5'(probes)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hit_cnt));
    chk({name, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_miss_cnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [CODE_W-1:0] d);
    int n;
    @(negedge clk);
    host_wr_req = 1'b1; host_wr_addr = a; host_wr_data = d;
    #1;
    n = 0;
    while (!ram_we && n < 20) begin @(negedge clk); #1; n++; end
    if (!ram_we) begin
      chk("hwr_we_timeout", 64'(ram_we), 64'd1);
      host_wr_req = 1'b0;
      return;
    end
    chk("hwr_addr", 64'(ram_addr), 64'(a));
    chk("hwr_din", 64'(ram_din), 64'(d));
    chk("hwr_ready_low", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("hwr_ack", 64'(host_wr_ack), 64'd1);
    chk("hwr_we_once", 64'(ram_we), 64'd0);
    host_wr_req = 1'b0;
    ref_tab[a] = d;
    @(negedge clk);
    chk("hwr_ack_pulse", 64'(host_wr_ack), 64'd0);
  endtask

  // Runs from the accepting cycle (t0) through the result handshake.
  task automatic finish_lookup(input int t0, input int stall, output logic [15:0] got);
    int          n;
    logic [15:0] exp;
    exp = exp_q.pop_front();
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'(rsp_valid), 64'd1);
      got = '0;
      rsp_ready = 1'b1;
      return;
    end
    got = {rsp_hit, rsp_index, rsp_probes};
    chk("rsp", 64'(got), 64'(exp));
    chk("latency", 64'(cyc - t0), 64'(exp[4:0]) + 64'd1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp", 64'({rsp_hit, rsp_index, rsp_probes}), 64'(got));
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk_counters("stall");
    end
    rsp_ready = 1'b1;
    @(negedge clk);
`ifdef WARRANT_LOOKUP_STATS_EN
    if (got[15]) exp_hit_cnt++;
    else exp_miss_cnt++;
`endif
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("ready_after", 64'(req_ready), 64'd1);
    chk_counters("post");
  endtask

  task automatic do_lookup(input logic [CODE_W-1:0] code, input int stall, output logic [15:0] got);
    int n;
    int t0;
    @(negedge clk);
    rsp_ready = (stall == 0);
    req_valid = 1'b1; req_code = code;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      got = '0;
      return;
    end
    t0 = cyc;
    exp_q.push_back(ref_lookup(code));
    finish_lookup(t0, stall, got);
  endtask

  function automatic logic [CODE_W-1:0] rand_code();
    logic [63:0] t;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) begin
      t = {$urandom(), $urandom()};
      return t[CODE_W-1:0];
    end
    if (sel == 1) return '0;
    return CODE_W'((longint'($urandom_range(1, 15)) << 10) | longint'($urandom_range(0, 15)));
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [CODE_W-1:0] code;
    logic              hit;
    logic [ADDR_W-1:0] idx;
    logic [4:0]        probes;
  } vec_t;

  localparam logic [CODE_W-1:0] CODE_S = 48'h303030303031;
  localparam logic [CODE_W-1:0] CODE_A = 48'h0000_0000_03FF;
  localparam logic [CODE_W-1:0] CODE_B = 48'h0000_0000_07FE;
  localparam logic [CODE_W-1:0] CODE_C = 48'h0000_0010_03FE;
  localparam logic [CODE_W-1:0] CODE_D = 48'h0000_4000_03FE;
  localparam logic [CODE_W-1:0] CODE_E = 48'h0100_0000_03FE;
  localparam logic [CODE_W-1:0] CODE_F = 48'h414243444546;

  vec_t        vecs [8];
  logic [15:0] got;
  int          t0;

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_tab[i] = '0; end
    reset = 1'b1; req_valid = 1'b0; req_code = '0; rsp_ready = 1'b1;
    host_wr_req = 1'b0; host_wr_addr = '0; host_wr_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ack", 64'(host_wr_ack), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk_counters("rst");
    reset = 1'b0;
    #1;
    chk("rst_rsp_fields", 64'({rsp_hit, rsp_index, rsp_probes}), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Table setup: "000001" at its home slot, four codes chained from 1023.
    host_write(10'h3CE, CODE_S);
    host_write(10'd1023, CODE_A);
    host_write(10'd0, CODE_B);
    host_write(10'd1, CODE_C);
    host_write(10'd2, CODE_D);

    vecs[0] = '{CODE_S, 1'b1, 10'h3CE, 5'd1};
    vecs[1] = '{CODE_B, 1'b1, 10'd0,   5'd2};
    vecs[2] = '{CODE_E, 1'b0, 10'd2,   5'd4};
    vecs[3] = '{CODE_D, 1'b1, 10'd2,   5'd4};
    vecs[4] = '{48'h0,  1'b0, 10'd0,   5'd1};
    vecs[5] = '{CODE_A, 1'b1, 10'd1023, 5'd1};
    vecs[6] = '{CODE_C, 1'b1, 10'd1,   5'd3};
    vecs[7] = '{48'h5,  1'b0, 10'd5,   5'd1};
    for (int i = 0; i < 8; i++) begin
      do_lookup(vecs[i].code, 0, got);
      chk($sformatf("vec%0d", i), 64'(got), 64'({vecs[i].hit, vecs[i].idx, vecs[i].probes}));
    end

    // Host write and lookup raised together: the write wins, lookup follows.
    @(negedge clk);
    host_wr_req = 1'b1; host_wr_addr = 10'(ref_hash(CODE_F)); host_wr_data = CODE_F;
    req_valid = 1'b1; req_code = CODE_F; rsp_ready = 1'b1;
    #1;
    chk("both_ready_low", 64'(req_ready), 64'd0);
    chk("both_we", 64'(ram_we), 64'd1);
    @(negedge clk);
    chk("both_ack", 64'(host_wr_ack), 64'd1);
    chk("both_ready_hwr", 64'(req_ready), 64'd0);
    host_wr_req = 1'b0;
    ref_tab[ref_hash(CODE_F)] = CODE_F;
    @(negedge clk);
    chk("both_ack_drop", 64'(host_wr_ack), 64'd0);
    chk("both_ready_idle", 64'(req_ready), 64'd1);
    t0 = cyc;
    exp_q.push_back(ref_lookup(CODE_F));
    finish_lookup(t0, 0, got);
    chk("both_lookup", 64'(got[15]), 64'd1);

    // Response held off by the consumer.
    do_lookup(CODE_S, 5, got);

    // Reset while probing drops the lookup; a new one then completes.
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b1; req_code = CODE_E;
    #1;
    chk("rp_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rp_in_probe", 64'(dbg_state), 64'(PROBE));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_hit_cnt = 0; exp_miss_cnt = 0;
    chk("rp_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rp_ram_we", 64'(ram_we), 64'd0);
    chk("rp_state", 64'(dbg_state), 64'(IDLE));
    chk_counters("rp");
    reset = 1'b0;
    do_lookup(CODE_B, 0, got);
    chk("rp_relookup", 64'(got), 64'({1'b1, 10'd0, 5'd2}));

    // Randomized traffic against the model.
    for (int it = 0; it < 160; it++) begin
      logic [CODE_W-1:0] c;
      c = rand_code();
      if ($urandom_range(0, 9) < 4 && c != 0)
        host_write(10'((ref_hash(c) + int'($urandom_range(0, 3))) % 1024), c);
      else
        do_lookup(c, int'($urandom_range(0, 2)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
